// File: rtl/alu_seq_unit.sv
// Execute-stage ALU: single-cycle logic/arithmetic ops plus an iterative
// shift-add multiplier that stalls the pipeline through ready_o for WIDTH cycles.
module alu_seq_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o
);

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  localparam logic [3:0] OP_MUL = 4'd5;

  state_t             state;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic [WIDTH-1:0]   acc;
  logic [SHAMT_W-1:0] cnt;

  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   acc_next;
  logic [SHAMT_W-1:0] shamt;
  logic               cnt_last;

  assign ready_o  = (state == IDLE);
  assign shamt    = data2_i[SHAMT_W-1:0];
  assign acc_next = acc + (mul_b[0] ? mul_a : '0);
  assign cnt_last = (cnt == SHAMT_W'(WIDTH - 1));

  // Codes 10-15 (and MUL, which never takes this path) produce zero.
  always_comb begin
    alu_res = '0;
    case (ctrl_i)
      4'd0:             alu_res = data1_i & data2_i;
      4'd1:             alu_res = data1_i ^ data2_i;
      4'd2:             alu_res = data1_i << shamt;
      4'd3, 4'd6, 4'd8: alu_res = data1_i + data2_i;
      4'd4, 4'd9:       alu_res = data1_i - data2_i;
      4'd7:             alu_res = $unsigned($signed(data1_i) >>> shamt);
      default:          alu_res = '0;
    endcase
  end

  // Flush has priority over everything, including the final MUL step.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      mul_a    <= '0;
      mul_b    <= '0;
      acc      <= '0;
      cnt      <= '0;
      result_o <= '0;
      zero_o   <= 1'b0;
      valid_o  <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (flush_i) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (valid_i) begin
              if (ctrl_i == OP_MUL) begin
                state <= MUL;
                mul_a <= data1_i;
                mul_b <= data2_i;
                acc   <= '0;
                cnt   <= '0;
              end else begin
                result_o <= alu_res;
                zero_o   <= (alu_res == '0);
                valid_o  <= 1'b1;
              end
            end
          end
          MUL: begin
            acc   <= acc_next;
            mul_a <= mul_a << 1;
            mul_b <= mul_b >> 1;
            cnt   <= cnt + 1'b1;
            if (cnt_last) begin
              result_o <= acc_next;
              zero_o   <= (acc_next == '0);
              valid_o  <= 1'b1;
              state    <= IDLE;
              cnt      <= '0;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
